// File: rtl/ysyx_25060170_mem_rsp_pkg.sv
// ysyx_25060170_mem_pkg
// Shared definitions for the memory responder slice: FSM state encoding,
// legal access sizes, default base address and the LFSR seed used when
// YSYX_25060170_MEM_RAND_DELAY_EN is defined.
package ysyx_25060170_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [31:0] LEN_BYTE     = 32'd1;
    localparam logic [31:0] LEN_HALF     = 32'd2;
    localparam logic [31:0] LEN_WORD     = 32'd4;
    localparam logic [31:0] DEFAULT_BASE = 32'h8000_0000;
    localparam logic [3:0]  LFSR_SEED    = 4'b1001;

    function automatic logic len_legal(input logic [31:0] len);
        return (len == LEN_BYTE) || (len == LEN_HALF) || (len == LEN_WORD);
    endfunction

endpackage

// File: rtl/ysyx_25060170_mem_rsp_if.sv
// ysyx_25060170_mem_rsp_if
// Request/response bus between a load/store requester and the memory
// responder.
//   req_valid/req_ready : request handshake
//   req_addr/req_wen/req_wdata/req_len : byte address, store flag,
//                         LSB-aligned store data, size in bytes (1/2/4)
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata/rsp_err   : LSB-aligned load data, illegal-request flag
// Modports: master = requester, slave = responder.
interface ysyx_25060170_mem_rsp_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [31:0] req_len;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_len, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_len, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/ysyx_25060170_lfsr4.sv
// ysyx_25060170_lfsr4
// 4-bit Fibonacci LFSR, polynomial x^4 + x^3 + 1, reseeded on reset.
//   clk    : clock (rising edge)
//   rst    : synchronous active-high reset, loads LFSR_SEED
//   i_adv  : advance one step this cycle
//   o_lfsr : current LFSR state
module ysyx_25060170_lfsr4
    import ysyx_25060170_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_adv,
    output logic [3:0] o_lfsr
);

    logic [3:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_adv) begin
            r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/ysyx_25060170_mem_rsp.sv
// ysyx_25060170_mem_rsp
// Single-outstanding load/store memory responder with fixed latency.
//   clk : clock, all logic on the rising edge
//   rst : synchronous active-high reset (storage is not cleared)
//   bus : ysyx_25060170_mem_rsp_if.slave (request/response handshakes)
// Parameters: DEPTH (32-bit words), BASE (byte address of word 0),
//             LATENCY (wait cycles between accept and entering RESP).
// Illegal requests (bad len, misaligned, out of range) answer with
// rsp_err=1, rsp_rdata=0 and no write. Stores answer with rsp_rdata=0.
// Optional feature: YSYX_25060170_MEM_RAND_DELAY_EN adds lfsr[1:0]
// extra wait cycles per request.
module ysyx_25060170_mem_rsp
    import ysyx_25060170_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter logic [31:0] BASE    = DEFAULT_BASE,
    parameter int unsigned LATENCY = 1
) (
    input logic clk,
    input logic rst,
    ysyx_25060170_mem_rsp_if.slave bus
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e      r_state;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_cnt;
    logic [31:0] r_addr;
    logic        r_wen;
    logic [31:0] r_wdata;
    logic [31:0] r_len;
    logic [31:0] r_mem [DEPTH];

    logic        w_accept;
    logic [31:0] w_wait;
    logic [31:0] w_cur_addr;
    logic        w_cur_wen;
    logic [31:0] w_cur_wdata;
    logic [31:0] w_cur_len;
    logic [31:0] w_idx;
    logic        w_in_range;
    logic        w_aligned;
    logic        w_err;
    logic [31:0] w_word;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;
    logic [31:0] w_rsp_data;
    logic [3:0]  w_be;
    logic [31:0] w_wd_sh;
    logic        w_enter_resp;
    logic        w_commit;

    assign w_accept = bus.req_valid & r_req_ready;

`ifdef YSYX_25060170_MEM_RAND_DELAY_EN
    logic [3:0] w_lfsr;

    ysyx_25060170_lfsr4 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .i_adv  (w_accept),
        .o_lfsr (w_lfsr)
    );

    assign w_wait = 32'(LATENCY) + {30'd0, w_lfsr[1:0]};
`else
    assign w_wait = 32'(LATENCY);
`endif

    // With zero wait the request goes straight to RESP on the accept edge,
    // so decode works on the live bus in IDLE and on the latched copy after.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_cur_addr  = bus.req_addr;
            w_cur_wen   = bus.req_wen;
            w_cur_wdata = bus.req_wdata;
            w_cur_len   = bus.req_len;
        end else begin
            w_cur_addr  = r_addr;
            w_cur_wen   = r_wen;
            w_cur_wdata = r_wdata;
            w_cur_len   = r_len;
        end
    end

    // Addresses below BASE wrap to huge indices and fail the range test.
    assign w_idx      = (w_cur_addr - BASE) >> 2;
    assign w_in_range = (w_idx < 32'(DEPTH));

    always_comb begin
        unique case (w_cur_len)
            LEN_BYTE: w_aligned = 1'b1;
            LEN_HALF: w_aligned = ~w_cur_addr[0];
            LEN_WORD: w_aligned = (w_cur_addr[1:0] == 2'b00);
            default:  w_aligned = 1'b0;
        endcase
    end

    assign w_err = ~len_legal(w_cur_len) | ~w_aligned | ~w_in_range;

    assign w_word    = w_in_range ? r_mem[w_idx[AW-1:0]] : '0;
    assign w_shifted = w_word >> {w_cur_addr[1:0], 3'b000};

    always_comb begin
        unique case (w_cur_len)
            LEN_BYTE: w_load_data = {24'd0, w_shifted[7:0]};
            LEN_HALF: w_load_data = {16'd0, w_shifted[15:0]};
            default:  w_load_data = w_shifted;
        endcase
    end

    assign w_rsp_data = (w_err | w_cur_wen) ? '0 : w_load_data;

    always_comb begin
        unique case (w_cur_len)
            LEN_BYTE: w_be = 4'b0001 << w_cur_addr[1:0];
            LEN_HALF: w_be = w_cur_addr[1] ? 4'b1100 : 4'b0011;
            default:  w_be = 4'b1111;
        endcase
    end

    assign w_wd_sh = w_cur_wdata << {w_cur_addr[1:0], 3'b000};

    assign w_enter_resp = ((r_state == S_IDLE) & w_accept & (w_wait == '0)) |
                          ((r_state == S_WAIT) & (r_cnt == '0));
    assign w_commit     = w_enter_resp & w_cur_wen & ~w_err & ~rst;

    // Storage has no reset; a request reset while in WAIT never commits.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx[AW-1:0]][8*i +: 8] <= w_wd_sh[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr      <= bus.req_addr;
                        r_wen       <= bus.req_wen;
                        r_wdata     <= bus.req_wdata;
                        r_len       <= bus.req_len;
                        r_req_ready <= 1'b0;
                        if (w_wait == '0) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_rsp_data;
                            r_rsp_err   <= w_err;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= w_wait - 32'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_rsp_data;
                        r_rsp_err   <= w_err;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_ysyx_25060170_mem_rsp.sv
// tb_ysyx_25060170_mem_rsp
// Scoreboard bench: the driver computes each expected response from a
// byte-array memory model and queues it; the monitor checks responses,
// accept-to-response timing, stability under back-pressure and idle zeros.
module tb_ysyx_25060170_mem_rsp;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned LAT    = 1;
    localparam longint unsigned BASE_L = 64'h8000_0000;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          wt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   force_stall = 0;
    exp_t sbq[$];
    logic [7:0] mdl [0:4*DEPTH-1];
    logic [3:0] lfsr_m = 4'b1001;

    ysyx_25060170_mem_rsp_if bus ();

    ysyx_25060170_mem_rsp #(
        .DEPTH   (DEPTH),
        .BASE    (32'h8000_0000),
        .LATENCY (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reference behaviour: legality from plain arithmetic, memory as bytes.
    function automatic void model(input logic [31:0] a, input logic w, input logic [31:0] d,
                                  input logic [31:0] l, output logic [31:0] rd, output logic err);
        longint unsigned la = a;
        longint unsigned ll = l;
        longint unsigned off;
        err = 1'b0;
        rd  = '0;
        if (!(ll == 1 || ll == 2 || ll == 4)) err = 1'b1;
        else if (la % ll != 0) err = 1'b1;
        if (la < BASE_L || la >= BASE_L + 4 * DEPTH) err = 1'b1;
        if (!err) begin
            off = la - BASE_L;
            for (int k = 0; k < int'(ll); k++) begin
                if (w) mdl[off + longint'(k)] = d[8*k +: 8];
                else   rd = rd | (32'(mdl[off + longint'(k)]) << (8 * k));
            end
        end
    endfunction

    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [31:0] l);
        int unsigned t = 0;
        exp_t e;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_wen   = w;
        bus.req_wdata = d;
        bus.req_len   = l;
        while (!bus.req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_timeout: req_ready=0 after %0d cycles, required 1", t);
            bus.req_valid = 1'b0;
            return;
        end
        model(a, w, d, l, e.rdata, e.err);
        e.acc = cyc + 1;
`ifdef YSYX_25060170_MEM_RAND_DELAY_EN
        e.wt   = LAT + int'(lfsr_m[1:0]);
        lfsr_m = {lfsr_m[2:0], lfsr_m[3] ^ lfsr_m[2]};
`else
        e.wt = LAT;
`endif
        sbq.push_back(e);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned t = 0;
        while ((sbq.size() != 0 || !bus.req_ready) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sbq.size());
        end
    endtask

    // Monitor: owns rsp_ready, pops the scoreboard on each handshake.
    initial begin
        exp_t        e;
        logic        seen = 1'b0;
        logic        hs_prev = 1'b0;
        int          stall_left = 0;
        logic [31:0] held_rdata = '0;
        logic        held_err = 1'b0;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
                hs_prev = 1'b0;
                stall_left = 0;
                bus.rsp_ready = 1'b0;
            end else begin
                if (hs_prev) check("ready_after_hs", 32'(bus.req_ready), 32'd1);
                hs_prev = 1'b0;
                if (bus.rsp_valid) begin
                    check("ready_while_busy", 32'(bus.req_ready), 32'd0);
                    if (!seen) begin
                        if (sbq.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_rsp: rsp_valid=1 with no request outstanding, required 0");
                        end else begin
                            e = sbq[0];
                            // cyc+1 is the edge that first samples rsp_valid high
                            check("latency", 32'(cyc + 1 - e.acc), 32'(e.wt + 1));
                            check("rdata", bus.rsp_rdata, e.rdata);
                            check("err", 32'(bus.rsp_err), 32'(e.err));
                        end
                        held_rdata = bus.rsp_rdata;
                        held_err   = bus.rsp_err;
                        seen = 1'b1;
                        if (force_stall != 0) begin
                            stall_left  = force_stall;
                            force_stall = 0;
                        end else begin
                            stall_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
                        end
                    end else begin
                        check("stable_rdata", bus.rsp_rdata, held_rdata);
                        check("stable_err", 32'(bus.rsp_err), 32'(held_err));
                    end
                    if (stall_left > 0) begin
                        bus.rsp_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bus.rsp_ready = 1'b1;
                        hs_prev = 1'b1;
                        seen = 1'b0;
                        if (sbq.size() != 0) void'(sbq.pop_front());
                    end
                end else begin
                    bus.rsp_ready = 1'b0;
                    check("idle_rdata_zero", bus.rsp_rdata, 32'd0);
                    check("idle_err_zero", 32'(bus.rsp_err), 32'd0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d responses outstanding", sbq.size());
        $fatal(1, "watchdog");
    end

    // Driver
    initial begin
        logic [31:0] a;
        logic [31:0] l;
        int unsigned t;
        int unsigned r;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_wen   = 1'b0;
        bus.req_wdata = '0;
        bus.req_len   = 32'd4;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rdata", bus.rsp_rdata, 32'd0);
        check("reset_err", 32'(bus.rsp_err), 32'd0);

        // Give every word a known value
        for (int i = 0; i < int'(DEPTH); i++)
            issue(32'h8000_0000 + 32'(4 * i), 1'b1, $urandom, 32'd4);

        // Word store/load, then a byte store merged into it
        issue(32'h8000_0000, 1'b1, 32'hDEAD_BEEF, 32'd4);
        issue(32'h8000_0000, 1'b0, 32'd0, 32'd4);
        issue(32'h8000_0003, 1'b1, 32'h0000_00AA, 32'd1);
        issue(32'h8000_0000, 1'b0, 32'd0, 32'd4);
        issue(32'h8000_0002, 1'b0, 32'd0, 32'd2);

        // Illegal requests, then readback
        issue(32'h8000_0001, 1'b0, 32'd0, 32'd2);
        issue(32'h8000_0000, 1'b0, 32'd0, 32'd3);
        issue(32'h7FFF_FFFC, 1'b0, 32'd0, 32'd4);
        issue(32'h8000_0001, 1'b1, 32'h1111_1111, 32'd2);
        issue(32'h8000_0100, 1'b1, 32'h2222_2222, 32'd4);
        issue(32'h8000_0000, 1'b0, 32'd0, 32'd4);
        issue(32'h8000_00FC, 1'b0, 32'd0, 32'd4);

        // Five cycles of back-pressure
        drain();
        force_stall = 5;
        issue(32'h8000_0000, 1'b0, 32'd0, 32'd4);
        drain();

        // Reset while a store sits in WAIT: no commit, no response
        t = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8000_0010;
        bus.req_wen   = 1'b1;
        bus.req_wdata = 32'h1234_5678;
        bus.req_len   = 32'd4;
        while (!bus.req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("rst_test_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        lfsr_m = 4'b1001;
        @(negedge clk);
        check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        issue(32'h8000_0010, 1'b0, 32'd0, 32'd4);

        // Back-to-back loads (latency follows the LFSR when enabled)
        for (int i = 0; i < 16; i++)
            issue(32'h8000_0000 + 32'(4 * i), 1'b0, 32'd0, 32'd4);

        // Randomized mix of legal and illegal traffic
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            case ($urandom_range(0, 2))
                0:       l = 32'd1;
                1:       l = 32'd2;
                default: l = 32'd4;
            endcase
            if (r == 9) begin
                case ($urandom_range(0, 3))
                    0:       l = 32'd0;
                    1:       l = 32'd3;
                    2:       l = 32'd8;
                    default: l = 32'd5;
                endcase
            end
            a = 32'h8000_0000 + ($urandom_range(0, 4 * DEPTH - 1) & ~(l - 32'd1));
            if (r == 7) a = 32'h8000_0000 + $urandom_range(0, 4 * DEPTH - 1);
            if (r == 8) begin
                case ($urandom_range(0, 2))
                    0:       a = 32'h7FFF_FFFC;
                    1:       a = 32'h8000_0000 + 32'(4 * DEPTH);
                    default: a = $urandom & 32'h7FFF_FFFC;
                endcase
            end
            issue(a, 1'($urandom_range(0, 1)), $urandom, l);
        end

        drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
